// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage LoongArch pipeline, between EX and WB.
// Define MEM_ALE_CHECK_EN to enable misaligned-load (ale) detection; otherwise ale is tied low.
module mem_stage #(
  parameter int BUS_IN_W  = 190,
  parameter int BUS_OUT_W = 185,
  parameter int BYP_W     = 53
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ex_mem_valid,
  output logic                 mem_allowin,
  input  logic [BUS_IN_W-1:0]  ex_mem_bus,
  input  logic [31:0]          data_sram_rdata,
  output logic                 mem_wb_valid,
  input  logic                 wb_allowin,
  output logic [BUS_OUT_W-1:0] mem_wb_bus,
  output logic [BYP_W-1:0]     mem_id_bus,
  output logic                 mem_ex,
  input  logic                 wb_ex,
  input  logic                 ertn_flush
);

  logic                mem_valid_q, mem_valid_d;
  logic                rbuf_valid_q, rbuf_valid_d;
  logic [31:0]         rbuf_q, rbuf_d;
  logic [BUS_IN_W-1:0] bus_q, bus_d;

  logic        mem_ready_go;
  logic        flush;
  logic        gr_we, res_from_mem, csr_we, csr_re, ertn, syscall, ale;
  logic [2:0]  mem_type;
  logic [1:0]  addr_low;
  logic [4:0]  dest;
  logic [31:0] pc, inst, result, csr_wmask, csr_wvalue;
  logic [13:0] csr_num;
  logic [31:0] rdata, load_data, final_result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        gr_we_out, bypass;

  assign {gr_we, res_from_mem, mem_type, addr_low, dest, pc, inst, result,
          csr_we, csr_re, csr_num, csr_wmask, csr_wvalue, ertn, syscall} = bus_q;

  assign mem_ready_go = 1'b1;
  assign flush        = wb_ex | ertn_flush;
  assign mem_allowin  = ~mem_valid_q | (mem_ready_go & wb_allowin);
  assign mem_wb_valid = mem_valid_q & mem_ready_go;

  always_comb begin
    mem_valid_d  = mem_valid_q;
    rbuf_valid_d = rbuf_valid_q;
    rbuf_d       = rbuf_q;
    bus_d        = bus_q;
    if (flush) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_mem_valid;
    end
    // Bus register loads on handshake even when a flush squashes the valid bit.
    if (ex_mem_valid & mem_allowin) begin
      bus_d = ex_mem_bus;
    end
    // SRAM data is only valid in the first MEM cycle; keep it for the whole WB stall.
    if (wb_allowin | flush) begin
      rbuf_valid_d = 1'b0;
    end else if (mem_valid_q & ~rbuf_valid_q) begin
      rbuf_valid_d = 1'b1;
      rbuf_d       = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q  <= 1'b0;
      rbuf_valid_q <= 1'b0;
      rbuf_q       <= '0;
      bus_q        <= '0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      rbuf_valid_q <= rbuf_valid_d;
      rbuf_q       <= rbuf_d;
      bus_q        <= bus_d;
    end
  end

  assign rdata = rbuf_valid_q ? rbuf_q : data_sram_rdata;

  always_comb begin
    ld_byte = rdata[7:0];
    ld_half = rdata[15:0];
    case (addr_low)
      2'd1: begin ld_byte = rdata[15:8];  ld_half = rdata[23:8];          end
      2'd2: begin ld_byte = rdata[23:16]; ld_half = rdata[31:16];         end
      2'd3: begin ld_byte = rdata[31:24]; ld_half = {8'h00, rdata[31:24]}; end
      default: ;
    endcase
    case (mem_type)
      3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {24'h000000, ld_byte};
      3'b110:  load_data = {16'h0000, ld_half};
      default: load_data = rdata;
    endcase
  end

  assign final_result = res_from_mem ? load_data : result;

`ifdef MEM_ALE_CHECK_EN
  assign ale = res_from_mem &
               ((((mem_type == 3'b010) | (mem_type == 3'b110)) & addr_low[0]) |
                ((mem_type == 3'b000) & (addr_low != 2'b00)));
`else
  assign ale = 1'b0;
`endif

  assign gr_we_out = gr_we & ~ale;
  assign bypass    = mem_valid_q & gr_we_out;
  assign mem_ex    = mem_valid_q & (ertn | syscall | ale);

  assign mem_wb_bus = {gr_we_out, dest, pc, inst, final_result, csr_we, csr_re, csr_num,
                       csr_wmask, csr_wvalue, ertn, syscall, ale};
  assign mem_id_bus = {bypass, dest, final_result, csr_re, csr_num};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized ALU/load traffic against a reference model,
// plus directed stall, flush, async-reset and misaligned-load scenarios.
`timescale 1ns/1ps
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         ex_mem_valid = 1'b0;
  logic         mem_allowin;
  logic [189:0] ex_mem_bus = '0;
  logic [31:0]  data_sram_rdata = '0;
  logic         mem_wb_valid;
  logic         wb_allowin = 1'b1;
  logic [184:0] mem_wb_bus;
  logic [52:0]  mem_id_bus;
  logic         mem_ex;
  logic         wb_ex = 1'b0;
  logic         ertn_flush = 1'b0;

  int checks = 0;
  int fails  = 0;

  mem_stage #(.BUS_IN_W(190), .BUS_OUT_W(185), .BYP_W(53)) dut (
    .clk(clk), .resetn(resetn), .ex_mem_valid(ex_mem_valid), .mem_allowin(mem_allowin),
    .ex_mem_bus(ex_mem_bus), .data_sram_rdata(data_sram_rdata), .mem_wb_valid(mem_wb_valid),
    .wb_allowin(wb_allowin), .mem_wb_bus(mem_wb_bus), .mem_id_bus(mem_id_bus), .mem_ex(mem_ex),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gr_we, res_from_mem;
    logic [2:0]  mem_type;
    logic [1:0]  addr_low;
    logic [4:0]  dest;
    logic [31:0] pc, inst, result;
    logic        csr_we, csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue;
    logic        ertn, syscall;
  } ins_t;

  function automatic ins_t rand_ins(input bit load);
    ins_t f;
    f.gr_we        = 1'($urandom);
    f.res_from_mem = load;
    f.mem_type     = 3'($urandom);
    f.addr_low     = 2'($urandom);
    f.dest         = 5'($urandom);
    f.pc           = $urandom;
    f.inst         = $urandom;
    f.result       = $urandom;
    f.csr_we       = 1'($urandom);
    f.csr_re       = 1'($urandom);
    f.csr_num      = 14'($urandom);
    f.csr_wmask    = $urandom;
    f.csr_wvalue   = $urandom;
    f.ertn         = 1'b0;
    f.syscall      = 1'b0;
    return f;
  endfunction

  function automatic ins_t load_ins(input logic [2:0] t, input logic [1:0] a);
    ins_t f;
    f = rand_ins(1'b1);
    f.gr_we    = 1'b1;
    f.mem_type = t;
    f.addr_low = a;
    return f;
  endfunction

  function automatic logic [189:0] pack_in(input ins_t f);
    return {f.gr_we, f.res_from_mem, f.mem_type, f.addr_low, f.dest, f.pc, f.inst, f.result,
            f.csr_we, f.csr_re, f.csr_num, f.csr_wmask, f.csr_wvalue, f.ertn, f.syscall};
  endfunction

  // Load result from the architectural rules using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh, b, h;
    sh = rd >> (32'(a) * 8);
    b  = sh & 32'h0000_00FF;
    h  = sh & 32'h0000_FFFF;
    case (t)
      3'b001:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b010:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return b;
      3'b110:  return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic ref_ale(input ins_t f);
`ifdef MEM_ALE_CHECK_EN
    int unsigned t, a;
    t = f.mem_type;
    a = f.addr_low;
    if (!f.res_from_mem) return 1'b0;
    if ((t == 2 || t == 6) && (a % 2 == 1)) return 1'b1;
    if (t == 0 && a != 0) return 1'b1;
    return 1'b0;
`else
    return (f.gr_we & 1'b0);
`endif
  endfunction

  function automatic logic [31:0] ref_final(input ins_t f, input logic [31:0] rd);
    return f.res_from_mem ? ref_load(f.mem_type, f.addr_low, rd) : f.result;
  endfunction

  function automatic logic [184:0] ref_wb(input ins_t f, input logic [31:0] rd);
    logic al;
    al = ref_ale(f);
    return {f.gr_we & ~al, f.dest, f.pc, f.inst, ref_final(f, rd), f.csr_we, f.csr_re,
            f.csr_num, f.csr_wmask, f.csr_wvalue, f.ertn, f.syscall, al};
  endfunction

  function automatic logic [52:0] ref_id(input ins_t f, input logic [31:0] rd, input logic v);
    return {v & f.gr_we & ~ref_ale(f), f.dest, ref_final(f, rd), f.csr_re, f.csr_num};
  endfunction

  function automatic logic ref_mex(input ins_t f, input logic v);
    return v & (f.ertn | f.syscall | ref_ale(f));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++; if (mem_allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin got=%b exp=1", mem_allowin); end
    checks++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", mem_wb_valid); end
    checks++; if (mem_wb_bus !== '0) begin fails++; $display("FAIL reset_wb_bus got=%h exp=0", mem_wb_bus); end
    checks++; if (mem_id_bus !== '0) begin fails++; $display("FAIL reset_id_bus got=%h exp=0", mem_id_bus); end
    checks++; if (mem_ex !== 1'b0) begin fails++; $display("FAIL reset_mem_ex got=%b exp=0", mem_ex); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    ins_t f;
    wb_allowin = 1'b1;
    for (int i = 0; i < 16; i++) begin
      f = rand_ins(1'b0);
      f.gr_we = 1'b1;
      ex_mem_bus = pack_in(f);
      ex_mem_valid = 1'b1;
      data_sram_rdata = $urandom;
      tick();
      checks++; if (mem_wb_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, mem_wb_valid); end
      checks++; if (mem_allowin !== 1'b1) begin fails++; $display("FAIL b2b_allowin[%0d] got=%b exp=1", i, mem_allowin); end
      checks++; if (mem_wb_bus !== ref_wb(f, data_sram_rdata)) begin fails++; $display("FAIL b2b_wb_bus[%0d] got=%h exp=%h", i, mem_wb_bus, ref_wb(f, data_sram_rdata)); end
      checks++; if (mem_id_bus !== ref_id(f, data_sram_rdata, 1'b1)) begin fails++; $display("FAIL b2b_id_bus[%0d] got=%h exp=%h", i, mem_id_bus, ref_id(f, data_sram_rdata, 1'b1)); end
      checks++; if (mem_ex !== 1'b0) begin fails++; $display("FAIL b2b_mem_ex[%0d] got=%b exp=0", i, mem_ex); end
    end
    ex_mem_valid = 1'b0;
    tick();
    checks++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%b exp=0", mem_wb_valid); end
  endtask

  task automatic test_load_ext();
    ins_t f;
    logic [2:0]  dt [3] = '{3'b001, 3'b101, 3'b110};
    logic [1:0]  da [3] = '{2'd3, 2'd3, 2'd2};
    logic [31:0] de [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
    wb_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f = load_ins(dt[i], da[i]);
      ex_mem_bus = pack_in(f);
      ex_mem_valid = 1'b1;
      tick();
      data_sram_rdata = 32'h80FF_1234;
      #1;
      checks++; if (mem_wb_bus[114:83] !== de[i]) begin fails++; $display("FAIL load_dir[%0d] got=%h exp=%h", i, mem_wb_bus[114:83], de[i]); end
    end
    for (int i = 0; i < 24; i++) begin
      f = rand_ins(1'b1);
      ex_mem_bus = pack_in(f);
      ex_mem_valid = 1'b1;
      tick();
      data_sram_rdata = $urandom;
      #1;
      checks++; if (mem_wb_bus !== ref_wb(f, data_sram_rdata)) begin fails++; $display("FAIL load_rand_wb[%0d] got=%h exp=%h", i, mem_wb_bus, ref_wb(f, data_sram_rdata)); end
      checks++; if (mem_id_bus !== ref_id(f, data_sram_rdata, 1'b1)) begin fails++; $display("FAIL load_rand_id[%0d] got=%h exp=%h", i, mem_id_bus, ref_id(f, data_sram_rdata, 1'b1)); end
      checks++; if (mem_ex !== ref_mex(f, 1'b1)) begin fails++; $display("FAIL load_rand_ex[%0d] got=%b exp=%b", i, mem_ex, ref_mex(f, 1'b1)); end
    end
    ex_mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall_hold();
    ins_t f, g;
    f = load_ins(3'b000, 2'd0);
    g = load_ins(3'b000, 2'd0);
    wb_allowin = 1'b1;
    ex_mem_bus = pack_in(f);
    ex_mem_valid = 1'b1;
    tick();
    data_sram_rdata = 32'hDEAD_BEEF;
    wb_allowin = 1'b0;
    ex_mem_bus = pack_in(g);
    #1;
    checks++; if (mem_allowin !== 1'b0) begin fails++; $display("FAIL stall_allowin0 got=%b exp=0", mem_allowin); end
    checks++; if (mem_wb_bus !== ref_wb(f, 32'hDEAD_BEEF)) begin fails++; $display("FAIL stall_first got=%h exp=%h", mem_wb_bus, ref_wb(f, 32'hDEAD_BEEF)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'h1111_1111;
      #1;
      checks++; if (mem_wb_bus !== ref_wb(f, 32'hDEAD_BEEF)) begin fails++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, mem_wb_bus, ref_wb(f, 32'hDEAD_BEEF)); end
      checks++; if (mem_allowin !== 1'b0) begin fails++; $display("FAIL stall_allowin[%0d] got=%b exp=0", i, mem_allowin); end
      checks++; if (mem_wb_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, mem_wb_valid); end
    end
    wb_allowin = 1'b1;
    #1;
    checks++; if (mem_allowin !== 1'b1) begin fails++; $display("FAIL stall_release got=%b exp=1", mem_allowin); end
    tick();
    checks++; if (mem_wb_bus !== ref_wb(g, 32'h1111_1111)) begin fails++; $display("FAIL stall_next got=%h exp=%h", mem_wb_bus, ref_wb(g, 32'h1111_1111)); end
    ex_mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_exception();
    ins_t f, g;
    wb_allowin = 1'b1;
    f = rand_ins(1'b0);
    f.syscall = 1'b1;
    ex_mem_bus = pack_in(f);
    ex_mem_valid = 1'b1;
    tick();
    checks++; if (mem_ex !== 1'b1) begin fails++; $display("FAIL exc_syscall got=%b exp=1", mem_ex); end
    f = rand_ins(1'b0);
    f.ertn = 1'b1;
    ex_mem_bus = pack_in(f);
    tick();
    checks++; if (mem_ex !== 1'b1) begin fails++; $display("FAIL exc_ertn got=%b exp=1", mem_ex); end
    for (int k = 0; k < 2; k++) begin
      g = rand_ins(1'b0);
      g.gr_we = 1'b1;
      g.syscall = 1'b1;
      ex_mem_bus = pack_in(g);
      ex_mem_valid = 1'b1;
      if (k == 0) wb_ex = 1'b1; else ertn_flush = 1'b1;
      tick();
      wb_ex = 1'b0;
      ertn_flush = 1'b0;
      ex_mem_valid = 1'b0;
      #1;
      checks++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL flush_valid[%0d] got=%b exp=0", k, mem_wb_valid); end
      checks++; if (mem_ex !== 1'b0) begin fails++; $display("FAIL flush_mem_ex[%0d] got=%b exp=0", k, mem_ex); end
      checks++; if (mem_wb_bus !== ref_wb(g, data_sram_rdata)) begin fails++; $display("FAIL flush_bus_load[%0d] got=%h exp=%h", k, mem_wb_bus, ref_wb(g, data_sram_rdata)); end
      checks++; if (mem_id_bus !== ref_id(g, data_sram_rdata, 1'b0)) begin fails++; $display("FAIL flush_id[%0d] got=%h exp=%h", k, mem_id_bus, ref_id(g, data_sram_rdata, 1'b0)); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    ins_t f, g;
    f = load_ins(3'b000, 2'd0);
    g = load_ins(3'b000, 2'd0);
    wb_allowin = 1'b1;
    ex_mem_bus = pack_in(f);
    ex_mem_valid = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    tick();
    wb_allowin = 1'b0;
    ex_mem_valid = 1'b0;
    tick();
    data_sram_rdata = 32'h1234_5678;
    #1;
    checks++; if (mem_wb_bus !== ref_wb(f, 32'hCAFE_F00D)) begin fails++; $display("FAIL arst_pre got=%h exp=%h", mem_wb_bus, ref_wb(f, 32'hCAFE_F00D)); end
    #1;
    resetn = 1'b0;
    #1;
    checks++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got=%b exp=0", mem_wb_valid); end
    checks++; if (mem_allowin !== 1'b1) begin fails++; $display("FAIL arst_allowin got=%b exp=1", mem_allowin); end
    checks++; if (mem_wb_bus !== '0) begin fails++; $display("FAIL arst_bus got=%h exp=0", mem_wb_bus); end
    #1;
    resetn = 1'b1;
    ex_mem_bus = pack_in(g);
    ex_mem_valid = 1'b1;
    tick();
    ex_mem_valid = 1'b0;
    #1;
    checks++; if (mem_wb_bus !== ref_wb(g, 32'h1234_5678)) begin fails++; $display("FAIL arst_rbuf_clear got=%h exp=%h", mem_wb_bus, ref_wb(g, 32'h1234_5678)); end
    wb_allowin = 1'b1;
    tick();
  endtask

  task automatic test_ale();
    ins_t f;
    logic [2:0] tt [3] = '{3'b000, 3'b010, 3'b001};
    logic [1:0] aa [3] = '{2'd2, 2'd1, 2'd1};
    logic       ea [3];
`ifdef MEM_ALE_CHECK_EN
    ea = '{1'b1, 1'b1, 1'b0};
`else
    ea = '{1'b0, 1'b0, 1'b0};
`endif
    wb_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f = load_ins(tt[i], aa[i]);
      ex_mem_bus = pack_in(f);
      ex_mem_valid = 1'b1;
      data_sram_rdata = 32'hA5C3_9687;
      tick();
      checks++; if (mem_wb_bus[0] !== ea[i]) begin fails++; $display("FAIL ale_flag[%0d] got=%b exp=%b", i, mem_wb_bus[0], ea[i]); end
      checks++; if (mem_ex !== ea[i]) begin fails++; $display("FAIL ale_mem_ex[%0d] got=%b exp=%b", i, mem_ex, ea[i]); end
      checks++; if (mem_wb_bus[184] !== ~ea[i]) begin fails++; $display("FAIL ale_gr_we[%0d] got=%b exp=%b", i, mem_wb_bus[184], ~ea[i]); end
      checks++; if (mem_id_bus[52] !== ~ea[i]) begin fails++; $display("FAIL ale_bypass[%0d] got=%b exp=%b", i, mem_id_bus[52], ~ea[i]); end
    end
    checks++; if (mem_wb_bus[114:83] !== 32'hFFFF_FF96) begin fails++; $display("FAIL ale_ldb_result got=%h exp=ffffff96", mem_wb_bus[114:83]); end
    ex_mem_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_ext();
    test_stall_hold();
    test_exception();
    test_async_reset();
    test_ale();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the five-stage LoongArch core; sits between EX and WB.
- Latches the EX→MEM bus and consumes the data-SRAM read data for the load issued in EX.
- Performs byte/half selection and sign/zero extension, and holds the read data across WB stalls.
- Produces the MEM→WB bus, the MEM→ID bypass bus, and the mem_ex exception indication back to EX.

Parameters:
- BUS_IN_W, 190, width of ex_mem_bus.
- BUS_OUT_W, 185, width of mem_wb_bus.
- BYP_W, 53, width of mem_id_bus.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ex_mem_valid  in  1  EX holds a valid instruction ready to advance.
- mem_allowin  out  1  MEM can accept this cycle.
- ex_mem_bus  in  190  MSB→LSB: gr_we1, res_from_mem1, mem_type3, addr_low2, dest5, pc32, inst32, result32, csr_we1, csr_re1, csr_num14, csr_wmask32, csr_wvalue32, ertn1, syscall1.
- data_sram_rdata  in  32  SRAM read data for the access issued by EX in the previous cycle.
- mem_wb_valid  out  1  MEM instruction valid toward WB.
- wb_allowin  in  1  WB can accept.
- mem_wb_bus  out  185  MSB→LSB: gr_we1, dest5, pc32, inst32, final_result32, csr_we1, csr_re1, csr_num14, csr_wmask32, csr_wvalue32, ertn1, syscall1, ale1.
- mem_id_bus  out  53  {bypass1, dest5, final_result32, csr_re1, csr_num14}.
- mem_ex  out  1  valid MEM instruction carries ertn, syscall or ale; EX uses it to suppress stores.
- wb_ex  in  1  exception flush from WB.
- ertn_flush  in  1  ertn flush from WB.

Behaviour:
- Reset (async, resetn=0):
  - mem_valid=0, rbuf_valid=0, bus register=0.
  - All outputs are therefore 0, except mem_allowin=1.
- Handshake:
  - mem_ready_go=1.
  - mem_wb_valid = mem_valid.
  - mem_allowin = ~mem_valid | wb_allowin.
- mem_valid update, by priority:
  1. wb_ex | ertn_flush → 0.
  2. else if mem_allowin → ex_mem_valid.
- Bus register: loads ex_mem_bus when ex_mem_valid & mem_allowin. Otherwise it holds. Flush does not clear it.
- Read-data hold buffer:
  - Capture: on a cycle with mem_valid & ~wb_allowin & ~rbuf_valid, rbuf ← data_sram_rdata and rbuf_valid ← 1.
  - Clear: rbuf_valid ← 0 on wb_allowin, wb_ex or ertn_flush. Clear wins over capture.
  - Effective rdata = rbuf_valid ? rbuf : data_sram_rdata.
  - A stall of any length returns the first-cycle data.
- Load extraction: shift = addr_low2*8; byte = rdata>>shift [7:0]; half = rdata>>shift [15:0].
- mem_type decode:
  - 000 ld.w → word.
  - 001 ld.b → sign-extended byte.
  - 010 ld.h → sign-extended half.
  - 101 ld.bu → zero-extended byte.
  - 110 ld.hu → zero-extended half.
  - Other codes → word.
- final_result = res_from_mem ? load_data : result32.
- Bypass and exception signals:
  - bypass = mem_valid & gr_we.
  - mem_ex = mem_valid & (ertn | syscall | ale).
- Flush vs. new entry: a flush in the same cycle as a handshake leaves mem_valid=0, even though the bus register loads.
- Output gating: the mem_wb_bus and mem_id_bus contents are not gated by valid; consumers qualify them with mem_wb_valid / bypass.

Optional Feature:
- Macro: MEM_ALE_CHECK_EN.
- Defined:
  - ale = res_from_mem & ((mem_type∈{010,110} & addr_low2[0]) | (mem_type==000 & addr_low2!=0)).
  - When ale=1, gr_we in mem_wb_bus is forced 0 and bypass is forced 0.
- Undefined: ale is tied 0. Port widths are unchanged.

Test Plan:
- Back-to-back ALU ops, wb_allowin=1 → each result32 appears on mem_wb_bus one cycle after entry; mem_allowin stays 1; bypass=1 with matching dest.
- ld.b at addr_low2=11, rdata=0x80FF_1234 → final_result=0xFFFF_FF80. Same access as ld.bu → 0x0000_0080. ld.hu at addr_low2=10 → 0x0000_80FF.
- Load with rdata=0xDEADBEEF, then wb_allowin=0 for 3 cycles while rdata changes to 0x11111111 → final_result stays 0xDEADBEEF; mem_allowin=0 during the stall; on wb_allowin=1 the instruction advances and rbuf_valid clears.
- Valid syscall in MEM → mem_ex=1. wb_ex pulse while ex_mem_valid=1 → mem_valid=0 next cycle, mem_ex=0.
- resetn asserted mid-stall with rbuf_valid=1 → mem_valid and rbuf_valid drop to 0 immediately, without waiting for a clock edge; mem_allowin=1.
- MEM_ALE_CHECK_EN defined: ld.w at addr_low2=10 → ale=1, mem_ex=1, gr_we=0. Macro undefined: ale=0, normal load result.
